// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encodings, PC step and NOP word.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MD_WAIT  = 2'd2
    } seq_state_t;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0000;

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module lu_hazard_detect (
    input  logic       memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign hazard = memread && (ex_rt != 5'd0)
                  && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pc_stall_ctrl.sv
// PC sequencer: next-PC select, PC/pipeline enables and flushes for
// load-use, branch, jump and multi-cycle mult/div hazards.
module pc_stall_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int PC_STEP   = cpu_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        md_start,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_busy
);

    import cpu_pkg::*;

    seq_state_t  st, st_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        md_seen, md_seen_nx;
    logic        lu_hazard;
    logic [31:0] pc_seq;
    logic [31:0] pc_raw;

    lu_hazard_detect u_lu (
        .memread (idex_memread),
        .ex_rt   (idex_rt),
        .id_rs   (ifid_rs),
        .id_rt   (ifid_rt),
        .hazard  (lu_hazard)
    );

    assign pc_seq  = pc_in + 32'(PC_STEP);
    assign pc_next = {pc_raw[31:2], 2'b00};

    always_comb begin
        pc_raw      = pc_seq;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
        st_nx       = ST_RUN;
        cnt_nx      = cnt;

        if (rst) begin
            pc_raw      = 32'd0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            cnt_nx      = 8'd0;
        end else begin
            unique case (st)
                ST_RUN: begin
                    if (branch_taken) begin
                        pc_raw     = branch_target;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (md_start && !md_seen) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_nx      = 8'(MD_CYCLES - 2);
                        st_nx       = ST_MD_WAIT;
                    end else if (lu_hazard) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        st_nx      = ST_LU_STALL;
                    end else if (jump) begin
                        pc_raw     = jump_target;
                        ifid_flush = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    // EX holds the bubble, so only the ID-side jump matters
                    if (jump) begin
                        pc_raw     = jump_target;
                        ifid_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    md_busy     = 1'b1;
                    if (cnt != 8'd0) begin
                        cnt_nx = cnt - 8'd1;
                        st_nx  = ST_MD_WAIT;
                    end
                end
                default: st_nx = ST_RUN;
            endcase
        end

        // The mult/div still sits in EX on the first RUN cycle after the wait
        if (rst)
            md_seen_nx = 1'b0;
        else if (st == ST_MD_WAIT && cnt == 8'd0)
            md_seen_nx = 1'b1;
        else if (idex_en)
            md_seen_nx = 1'b0;
        else
            md_seen_nx = md_seen;
    end

    always_ff @(posedge clk) begin
        st      <= st_nx;
        cnt     <= cnt_nx;
        md_seen <= md_seen_nx;
    end

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Directed bench for pc_stall_ctrl with a cycle-level reference model.
module tb_pc_stall_ctrl;

    localparam int MDC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        md_start;
    logic [31:0] pc_next;
    logic        pc_en, ifid_en, idex_en;
    logic        ifid_flush, idex_flush, exmem_flush, md_busy;

    int total = 0;
    int bad   = 0;

    pc_stall_ctrl #(.MD_CYCLES(MDC), .PC_STEP(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .idex_memread  (idex_memread),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .md_start      (md_start),
        .pc_next       (pc_next),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .md_busy       (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining freeze cycles, pending load-use slot, post-md guard
    int freeze_left = 0;
    bit lu_slot     = 0;
    bit md_guard    = 0;

    always @(negedge clk) begin
        logic [31:0] e_pc;
        bit e_pc_en, e_ifid_en, e_idex_en;
        bit e_ifl, e_idl, e_exl, e_busy, haz;
        e_pc      = (pc_in + 32'd4) & 32'hFFFF_FFFC;
        e_pc_en   = 1; e_ifid_en = 1; e_idex_en = 1;
        e_ifl     = 0; e_idl = 0; e_exl = 0; e_busy = 0;
        haz = idex_memread && idex_rt != 0
              && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (rst) begin
            e_pc = 0;
            e_pc_en = 0; e_ifid_en = 0; e_idex_en = 0;
            e_ifl = 1; e_idl = 1; e_exl = 1;
            freeze_left = 0; lu_slot = 0; md_guard = 0;
        end else if (freeze_left > 0) begin
            e_pc_en = 0; e_ifid_en = 0; e_idex_en = 0;
            e_exl = 1; e_busy = 1;
            freeze_left--;
            md_guard = (freeze_left == 0);
        end else if (lu_slot) begin
            if (jump) begin
                e_pc = jump_target & 32'hFFFF_FFFC;
                e_ifl = 1;
            end
            lu_slot = 0; md_guard = 0;
        end else if (branch_taken) begin
            e_pc = branch_target & 32'hFFFF_FFFC;
            e_ifl = 1; e_idl = 1; md_guard = 0;
        end else if (md_start && !md_guard) begin
            e_pc_en = 0; e_ifid_en = 0; e_idex_en = 0; e_exl = 1;
            freeze_left = MDC - 1;
        end else if (haz) begin
            e_pc_en = 0; e_ifid_en = 0; e_idl = 1;
            lu_slot = 1; md_guard = 0;
        end else begin
            if (jump) begin
                e_pc = jump_target & 32'hFFFF_FFFC;
                e_ifl = 1;
            end
            md_guard = 0;
        end
        chk("m_pc_next", pc_next, e_pc);
        chk("m_pc_en", 32'(pc_en), 32'(e_pc_en));
        chk("m_ifid_en", 32'(ifid_en), 32'(e_ifid_en));
        chk("m_idex_en", 32'(idex_en), 32'(e_idex_en));
        chk("m_ifid_flush", 32'(ifid_flush), 32'(e_ifl));
        chk("m_idex_flush", 32'(idex_flush), 32'(e_idl));
        chk("m_exmem_flush", 32'(exmem_flush), 32'(e_exl));
        chk("m_md_busy", 32'(md_busy), 32'(e_busy));
    end

    task automatic idle();
        rst = 0; jump = 0; jump_target = 0;
        branch_taken = 0; branch_target = 0;
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        md_start = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1; pc_in = 32'h40;
        settle();
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_pc_next", pc_next, 0);
        chk("rst_flush", {29'd0, ifid_flush, idex_flush, exmem_flush}, 7);
        chk("rst_md_busy", 32'(md_busy), 0);
        tick();
        tick();
        rst = 0;
        settle();
        chk("rel_pc_next", pc_next, 32'h44);
        chk("rel_pc_en", 32'(pc_en), 1);

        // load-use on rs
        tick();
        idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        settle();
        chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_idex_flush", 32'(idex_flush), 1);
        tick();
        settle();
        chk("lu_slot_pc_en", 32'(pc_en), 1);
        tick();
        idex_rt = 0;
        settle();
        chk("lu_r0_pc_en", 32'(pc_en), 1);
        chk("lu_r0_flush", 32'(idex_flush), 0);

        // load-use on rt, jump honoured and branch ignored in the stall slot
        tick();
        idle(); idex_memread = 1; idex_rt = 5; ifid_rt = 5;
        settle();
        chk("lu_rt_pc_en", 32'(pc_en), 0);
        tick();
        branch_taken = 1; branch_target = 32'h900;
        jump = 1; jump_target = 32'h80;
        settle();
        chk("lu_jmp_pc", pc_next, 32'h80);
        chk("lu_br_ign", 32'(idex_flush), 0);

        // branch beats jump and md_start
        tick();
        idle();
        branch_taken = 1; branch_target = 32'h100;
        jump = 1; jump_target = 32'h300; md_start = 1;
        settle();
        chk("br_pc_next", pc_next, 32'h100);
        chk("br_flush", {30'd0, ifid_flush, idex_flush}, 3);
        tick();
        idle();
        settle();
        chk("br_no_md", 32'(md_busy), 0);
        chk("br_no_md_en", 32'(pc_en), 1);

        // mult/div freeze, then guard on the following cycle
        tick();
        md_start = 1;
        settle();
        chk("md_issue_en", 32'(pc_en), 0);
        chk("md_issue_busy", 32'(md_busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            md_start = 0;
            settle();
            chk("md_wait_en", 32'(pc_en), 0);
            chk("md_wait_busy", 32'(md_busy), 1);
        end
        tick();
        md_start = 1;
        settle();
        chk("md_back_en", 32'(pc_en), 1);
        chk("md_back_busy", 32'(md_busy), 0);
        tick();
        md_start = 0;
        settle();
        chk("md_after_en", 32'(pc_en), 1);

        // reset aborts the freeze
        tick();
        md_start = 1;
        tick();
        md_start = 0;
        settle();
        chk("md2_busy", 32'(md_busy), 1);
        tick();
        rst = 1;
        settle();
        chk("md_rst_busy", 32'(md_busy), 0);
        chk("md_rst_en", 32'(pc_en), 0);
        tick();
        rst = 0;
        settle();
        chk("post_rst_en", 32'(pc_en), 1);
        chk("post_rst_busy", 32'(md_busy), 0);
        tick();
        settle();
        chk("post_rst_en2", 32'(pc_en), 1);

        // wrap and jump alignment
        tick();
        pc_in = 32'hFFFF_FFFC;
        settle();
        chk("wrap_pc", pc_next, 32'h0);
        tick();
        jump = 1; jump_target = 32'h203;
        settle();
        chk("jmp_align", pc_next, 32'h200);
        chk("jmp_flush", 32'(ifid_flush), 1);

        // mixed traffic checked by the model only
        for (int i = 0; i < 200; i++) begin
            tick();
            idle();
            pc_in         = $urandom;
            rst           = ($urandom_range(0, 39) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            jump_target   = $urandom;
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = $urandom;
            idex_memread  = ($urandom_range(0, 3) == 0);
            idex_rt       = 5'($urandom_range(0, 3));
            ifid_rs       = 5'($urandom_range(0, 3));
            ifid_rt       = 5'($urandom_range(0, 3));
            md_start      = ($urandom_range(0, 9) == 0);
        end

        tick();
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
